// File: rtl/rmii_txd_serializer.sv
// -----------------------------------------------------------------------------
// rmii_txd_serializer
//
// RMII transmit serializer. Takes one byte at a time from the MAC/UDP frame
// builder and shifts it onto the 2-bit RMII TXD bus, least-significant dibit
// first, framed by TX_EN. Each byte is requested with a one-cycle strobe
// (isSaveData), so a producer that answers within 3 cycles keeps the line
// gapless: one byte every 4 clocks at 100 Mb/s. Once a frame ends, at least
// IFG_CYCLES idle clocks pass before the next frame is accepted.
//
// Optional feature macro: RMII_TXD_SPEED10_EN
//   When defined, the I_speed10 input is added. With I_speed10=1 (sampled
//   only while idle) each dibit is held for 10 clocks and the inter-frame gap
//   is stretched to IFG_CYCLES*10 clocks. When undefined, the port is absent
//   and the timing is fixed at 100 Mb/s.
//
// Parameters
//   IFG_CYCLES  minimum idle clocks with O_txen=0 after a frame (0 = none)
//
// Ports
//   I_clk50m    in   1  50 MHz RMII reference clock, rising edge
//   I_rst       in   1  asynchronous reset, active-low
//   I_txen      in   1  producer has a byte on I_data; high for whole frame
//   I_data      in   8  byte to send; valid whenever isSaveData=1
//   I_speed10   in   1  10 Mb/s select (only with RMII_TXD_SPEED10_EN)
//   O_txd       out  2  RMII TXD[1:0], registered
//   O_txen      out  1  RMII TX_EN, registered
//   isSaveData  out  1  byte-accept strobe; I_data captured at end of cycle
// -----------------------------------------------------------------------------
module rmii_txd_serializer #(
   parameter int unsigned IFG_CYCLES = 48
) (
   input  logic       I_clk50m,
   input  logic       I_rst,
   input  logic       I_txen,
   input  logic [7:0] I_data,
`ifdef RMII_TXD_SPEED10_EN
   input  logic       I_speed10,
`endif
   output logic [1:0] O_txd,
   output logic       O_txen,
   output logic       isSaveData
);

   // Longest gap the counter must cover, and the resulting counter width.
`ifdef RMII_TXD_SPEED10_EN
   localparam int unsigned GAP_MAX = IFG_CYCLES * 10;
`else
   localparam int unsigned GAP_MAX = IFG_CYCLES;
`endif
   localparam int unsigned CNT_W    = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
   // Terminal counts; only used when the GAP state is actually entered.
   localparam int unsigned GAP_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
`ifdef RMII_TXD_SPEED10_EN
   localparam int unsigned GAP10_LAST = (GAP_MAX > 0) ? GAP_MAX - 1 : 0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            state_q;
   logic [1:0]        phase_q;
   logic [1:0]        phase_d;
   logic [7:0]        shreg_q;
   logic [CNT_W-1:0]  ifg_cnt_q;
   logic              dibit_last;
   logic              gap_last;

`ifdef RMII_TXD_SPEED10_EN
   logic              speed10_q;
   logic [3:0]        sub_q;
`endif

   // Select dibit p (bits [2p+1:2p]) of a byte.
   function automatic logic [1:0] dibit_sel(input logic [7:0] b, input logic [1:0] p);
      return b[{p, 1'b0} +: 2];
   endfunction

   assign phase_d = phase_q + 2'd1;

   // dibit_last marks the final clock of the current dibit. At 100 Mb/s every
   // clock is the last; at 10 Mb/s it is the tenth clock of the hold.
   // gap_last marks the final clock of the inter-frame gap.
`ifdef RMII_TXD_SPEED10_EN
   assign dibit_last = !speed10_q || (sub_q == 4'd9);
   assign gap_last   = speed10_q ? (ifg_cnt_q == CNT_W'(GAP10_LAST))
                                 : (ifg_cnt_q == CNT_W'(GAP_LAST));
`else
   assign dibit_last = 1'b1;
   assign gap_last   = (ifg_cnt_q == CNT_W'(GAP_LAST));
`endif

   // Accept strobe. The GAP state already enforces the inter-frame gap, so
   // being in IDLE implies the gap is done. Gated by I_rst so that it drops
   // immediately while reset is asserted.
   always_comb begin
      isSaveData = 1'b0;
      if (I_rst && I_txen) begin
         if (state_q == S_IDLE)
            isSaveData = 1'b1;
         else if ((state_q == S_SEND) && (phase_q == 2'd3) && dibit_last)
            isSaveData = 1'b1;
      end
   end

   // Byte shift register: pure data, loaded on every accepted byte.
   always_ff @(posedge I_clk50m) begin
      if (isSaveData)
         shreg_q <= I_data;
   end

   // Control FSM with registered RMII outputs.
   always_ff @(posedge I_clk50m or negedge I_rst) begin
      if (!I_rst) begin
         state_q   <= S_IDLE;
         phase_q   <= 2'd0;
         ifg_cnt_q <= '0;
         O_txd     <= 2'b00;
         O_txen    <= 1'b0;
`ifdef RMII_TXD_SPEED10_EN
         speed10_q <= 1'b0;
         sub_q     <= 4'd0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
`ifdef RMII_TXD_SPEED10_EN
               // Speed is latched only while idle; it stays fixed for the
               // whole frame and its trailing gap.
               speed10_q <= I_speed10;
               sub_q     <= 4'd0;
`endif
               if (isSaveData) begin
                  O_txd   <= I_data[1:0];
                  O_txen  <= 1'b1;
                  phase_q <= 2'd0;
                  state_q <= S_SEND;
               end
            end

            S_SEND: begin
               if (!dibit_last) begin
`ifdef RMII_TXD_SPEED10_EN
                  sub_q <= sub_q + 4'd1;
`endif
               end else begin
`ifdef RMII_TXD_SPEED10_EN
                  sub_q <= 4'd0;
`endif
                  if (phase_q != 2'd3) begin
                     phase_q <= phase_d;
                     O_txd   <= dibit_sel(shreg_q, phase_d);
                  end else if (I_txen) begin
                     // Back-to-back byte: first dibit straight from I_data,
                     // the shift register is loaded on the same edge.
                     phase_q <= 2'd0;
                     O_txd   <= I_data[1:0];
                  end else begin
                     phase_q   <= 2'd0;
                     O_txd     <= 2'b00;
                     O_txen    <= 1'b0;
                     ifg_cnt_q <= '0;
                     state_q   <= (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
                  end
               end
            end

            S_GAP: begin
               if (gap_last) begin
                  ifg_cnt_q <= '0;
                  state_q   <= S_IDLE;
               end else begin
                  ifg_cnt_q <= ifg_cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
               O_txd   <= 2'b00;
               O_txen  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rmii_txd_serializer.sv
// -----------------------------------------------------------------------------
// tb_rmii_txd_serializer
//
// Directed bench for rmii_txd_serializer (IFG_CYCLES=48). Inputs change 1 ns
// after the rising edge and outputs are sampled 2 ns after it. When
// RMII_TXD_SPEED10_EN is defined the 10 Mb/s timing is exercised as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rmii_txd_serializer;

   logic       I_clk50m = 1'b0;
   logic       I_rst;
   logic       I_txen;
   logic [7:0] I_data;
`ifdef RMII_TXD_SPEED10_EN
   logic       I_speed10;
`endif
   logic [1:0] O_txd;
   logic       O_txen;
   logic       isSaveData;

   int n_checks = 0;
   int n_pass   = 0;

   always #10 I_clk50m = ~I_clk50m;

   rmii_txd_serializer #(.IFG_CYCLES(48)) dut (
      .I_clk50m   (I_clk50m),
      .I_rst      (I_rst),
      .I_txen     (I_txen),
      .I_data     (I_data),
`ifdef RMII_TXD_SPEED10_EN
      .I_speed10  (I_speed10),
`endif
      .O_txd      (O_txd),
      .O_txen     (O_txen),
      .isSaveData (isSaveData)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // One clock: advance past the rising edge, drive inputs, then settle.
   task automatic cyc(input logic txen, input logic [7:0] data);
      @(posedge I_clk50m);
      #1;
      I_txen = txen;
      I_data = data;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [7:0] pre [8];
   logic [7:0] exp_b;
   int         hi, bad, sdbad, idx, ph, j;

   initial begin
      I_rst  = 1'b0;
      I_txen = 1'b0;
      I_data = 8'h00;
`ifdef RMII_TXD_SPEED10_EN
      I_speed10 = 1'b0;
`endif
      repeat (3) @(posedge I_clk50m);
      #2;
      chk("rst_txd",  O_txd, 2'b00);
      chk("rst_txen", O_txen, 1'b0);
      chk("rst_sd",   isSaveData, 1'b0);
      @(posedge I_clk50m);
      #1 I_rst = 1'b1;
      idle(2);

      // Single byte 0xD5 -> dibits 01,01,01,11
      cyc(1'b1, 8'hD5);
      chk("d5_sd", isSaveData, 1'b1);
      chk("d5_txen_pre", O_txen, 1'b0);
      cyc(1'b0, 8'h00);
      chk("d5_txen0", O_txen, 1'b1);
      chk("d5_txd0", O_txd, 2'b01);
      chk("d5_sd_off", isSaveData, 1'b0);
      cyc(1'b0, 8'h00); chk("d5_txd1", O_txd, 2'b01);
      cyc(1'b0, 8'h00); chk("d5_txd2", O_txd, 2'b01);
      cyc(1'b0, 8'h00); chk("d5_txd3", O_txd, 2'b11);
      chk("d5_txen3", O_txen, 1'b1);
      cyc(1'b0, 8'h00);
      chk("d5_txen_end", O_txen, 1'b0);
      chk("d5_txd_end", O_txd, 2'b00);
      idle(60);

      // Preamble 7x0x55 + 0xD5, streaming producer
      for (int b = 0; b < 7; b++) pre[b] = 8'h55;
      pre[7] = 8'hD5;
      cyc(1'b1, pre[0]);
      chk("pre_sd_first", isSaveData, 1'b1);
      hi = 0; bad = 0; sdbad = 0;
      for (int k = 1; k <= 32; k++) begin
         idx = (k + 3) / 4;
         if (idx > 7) idx = 7;
         cyc(k <= 28, pre[idx]);
         exp_b = pre[(k - 1) / 4];
         ph    = (k - 1) % 4;
         if (O_txen === 1'b1) hi++;
         if (O_txd !== exp_b[2*ph +: 2]) bad++;
         if (isSaveData !== ((k % 4 == 0) && (k <= 28))) sdbad++;
      end
      chk("pre_last_dibit", O_txd, 2'b11);
      cyc(1'b0, 8'h00);
      chk("pre_txen_end", O_txen, 1'b0);
      chk("pre_len", hi, 32);
      chk("pre_txd_errs", bad, 0);
      chk("pre_sd_errs", sdbad, 0);
      idle(60);

      // 0xA5 with I_txen dropped at phase 1 -> 01,01,10,10 still sent
      cyc(1'b1, 8'hA5);
      chk("a5_sd", isSaveData, 1'b1);
      cyc(1'b1, 8'hA5); chk("a5_txd0", O_txd, 2'b01);
      cyc(1'b0, 8'hFF); chk("a5_txd1", O_txd, 2'b01);
      cyc(1'b0, 8'hFF); chk("a5_txd2", O_txd, 2'b10);
      cyc(1'b0, 8'hFF); chk("a5_txd3", O_txd, 2'b10);
      chk("a5_txen3", O_txen, 1'b1);
      cyc(1'b0, 8'hFF); chk("a5_txen_end", O_txen, 1'b0);
      idle(60);

      // Back-to-back frames: second request held through the gap
      cyc(1'b1, 8'h3C);
      chk("ifg_sd_first", isSaveData, 1'b1);
      cyc(1'b1, 8'h12);
      cyc(1'b1, 8'h12);
      cyc(1'b1, 8'h12);
      cyc(1'b0, 8'h12);
      cyc(1'b1, 8'h12);
      chk("ifg_fall", O_txen, 1'b0);
      hi = 0;
      j  = 0;
      while ((isSaveData !== 1'b1) && (j < 100)) begin
         j++;
         cyc(1'b1, 8'h12);
         if (O_txen !== 1'b0) hi++;
      end
      chk("ifg_wait", j, 48);
      chk("ifg_txen_low", hi, 0);
      // 0x12 -> dibits 10,00,01,00
      cyc(1'b0, 8'h00); chk("ifg_txen2", O_txen, 1'b1);
      chk("ifg_txd0", O_txd, 2'b10);
      cyc(1'b0, 8'h00); chk("ifg_txd1", O_txd, 2'b00);
      cyc(1'b0, 8'h00); chk("ifg_txd2", O_txd, 2'b01);
      cyc(1'b0, 8'h00); chk("ifg_txd3", O_txd, 2'b00);
      idle(60);

      // Reset in the middle of a frame
      cyc(1'b1, 8'hFF);
      cyc(1'b1, 8'hFF);
      chk("mrst_pre_txen", O_txen, 1'b1);
      #1 I_rst = 1'b0;
      #1;
      chk("mrst_txen", O_txen, 1'b0);
      chk("mrst_txd",  O_txd, 2'b00);
      chk("mrst_sd",   isSaveData, 1'b0);
      @(posedge I_clk50m);
      #1;
      chk("mrst_hold_txen", O_txen, 1'b0);
      I_rst = 1'b1;
      #1;
      chk("mrst_idle_sd", isSaveData, 1'b1);
      I_txen = 1'b0;
      idle(3);
      chk("mrst_after_txen", O_txen, 1'b0);

`ifdef RMII_TXD_SPEED10_EN
      // 10 Mb/s: two 0x0F bytes, each 11 x20 then 00 x20, strobe every 40
      I_speed10 = 1'b1;
      idle(2);
      cyc(1'b1, 8'h0F);
      chk("s10_sd_first", isSaveData, 1'b1);
      bad = 0; sdbad = 0; hi = 0;
      for (int k = 1; k <= 80; k++) begin
         cyc(k <= 40, 8'h0F);
         if (O_txen === 1'b1) hi++;
         if (O_txd !== ((((k - 1) % 40) < 20) ? 2'b11 : 2'b00)) bad++;
         if (isSaveData !== (k == 40)) sdbad++;
      end
      cyc(1'b0, 8'h00);
      chk("s10_txen_end", O_txen, 1'b0);
      chk("s10_len", hi, 80);
      chk("s10_txd_errs", bad, 0);
      chk("s10_sd_errs", sdbad, 0);
      I_speed10 = 1'b0;
      idle(500);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
